// File: rtl/if_id_stage.sv
// Fetch-to-decode pipeline register: captures PC and ROM word, handles stall/bubble/flush and misaligned fetch.
// Define IF_ID_PERF_EN to build the saturating fetch/bubble performance counters.
module if_id_stage #(
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chip_en,
    input  logic [31:0] if_pc,
    input  logic [31:0] rom_inst,
    input  logic [5:0]  stall_en,
    input  logic        flush,
    output logic        rom_ce,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid,
    output logic        id_adel,
    output logic [31:0] fetch_cnt,
    output logic [31:0] bubble_cnt
);

    typedef enum logic [1:0] {
        ACT_CAPTURE,
        ACT_BUBBLE,
        ACT_HOLD
    } action_e;

    action_e     action;
    logic        misaligned;
    logic [31:0] id_pc_q,   id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic        id_valid_q, id_valid_d;
    logic        id_adel_q,  id_adel_d;

    // Stall bits for other stages are intentionally not consumed here.
    logic unused_stall;
    assign unused_stall = ^{stall_en[5:3], stall_en[0]};

    assign rom_ce     = chip_en;
    assign misaligned = |if_pc[1:0];

    // Flush outranks an idle fetch, which outranks any stall combination.
    always_comb begin
        if (flush || !chip_en || (stall_en[1] && !stall_en[2])) begin
            action = ACT_BUBBLE;
        end else if (stall_en[1]) begin
            action = ACT_HOLD;
        end else begin
            action = ACT_CAPTURE;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch can be inferred.
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
        id_adel_d  = id_adel_q;
        case (action)
            ACT_BUBBLE: begin
                id_pc_d    = 32'h0;
                id_inst_d  = NOP_WORD;
                id_valid_d = 1'b0;
                id_adel_d  = 1'b0;
            end
            ACT_CAPTURE: begin
                id_pc_d    = if_pc;
                id_inst_d  = misaligned ? NOP_WORD : rom_inst;
                id_valid_d = 1'b1;
                id_adel_d  = misaligned;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            id_pc_q    <= 32'h0;
            id_inst_q  <= NOP_WORD;
            id_valid_q <= 1'b0;
            id_adel_q  <= 1'b0;
        end else begin
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
            id_adel_q  <= id_adel_d;
        end
    end

    assign id_pc    = id_pc_q;
    assign id_inst  = id_inst_q;
    assign id_valid = id_valid_q;
    assign id_adel  = id_adel_q;

`ifdef IF_ID_PERF_EN
    logic [31:0] fetch_cnt_q,  fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    // Both counters stick at all-ones rather than wrapping.
    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (action == ACT_CAPTURE && fetch_cnt_q != 32'hFFFF_FFFF) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (action == ACT_BUBBLE && bubble_cnt_q != 32'hFFFF_FFFF) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q  <= 32'h0;
            bubble_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fetch_cnt  = fetch_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    assign fetch_cnt  = 32'h0;
    assign bubble_cnt = 32'h0;
`endif

endmodule
